// File: rtl/pbit_update_if.sv
// Handshake bundle for one p-bit update stage: MAC current in, p-bit state out.
interface pbit_update_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [5:0] I_in;
  logic              clamp_en;
  logic              clamp_val;
  logic              out_valid;
  logic              out_ready;
  logic              p_out;

  modport master (
    output in_valid, I_in, clamp_en, clamp_val, out_ready,
    input  in_ready, out_valid, p_out
  );

  modport slave (
    input  in_valid, I_in, clamp_en, clamp_val, out_ready,
    output in_ready, out_valid, p_out
  );
endinterface

// File: rtl/pbit_update.sv
// Stochastic p-bit neuron: p = sgn(sat(I << GAIN_SHIFT) + r), r from a 16-bit LFSR.
// Two register stages (scaled current + noise sample, then the p-bit state) with
// valid/ready backpressure. Optional macro PBIT_FLIP_CNT_EN adds flip_count_o,
// a saturating count of stage-2 loads that change the p-bit.
module pbit_update #(
  parameter int          GAIN_SHIFT = 4,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  pbit_update_if.slave  pb
`ifdef PBIT_FLIP_CNT_EN
  ,
  output logic [15:0]   flip_count_o
`endif
);

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  logic [15:0]       lfsr_q, lfsr_d;
  logic signed [8:0] s_q, s_d;
  logic signed [7:0] r_q, r_d;
  logic              s1_valid_q, s1_valid_d;
  logic              out_valid_q, out_valid_d;
  logic              p_out_q, p_out_d;

  logic               accept;
  logic               stage2_load;
  logic               in_ready;
  logic               lfsr_fb;
  logic signed [11:0] shifted;
  logic signed [8:0]  s_sat;
  logic signed [9:0]  sum;
  logic               p_next;

  // Handshake qualifiers: stage 2 drains when the output slot is free or being consumed.
  always_comb begin
    stage2_load = s1_valid_q & (~out_valid_q | pb.out_ready);
    in_ready    = ~s1_valid_q | stage2_load;
    accept      = pb.in_valid & in_ready;
  end

  // Gain scaling and saturation of the input current to [-128, +128].
  always_comb begin
    shifted = $signed({{6{pb.I_in[5]}}, pb.I_in}) <<< GAIN_SHIFT;
    if (shifted > 12'sd128)       s_sat = 9'sd128;
    else if (shifted < -12'sd128) s_sat = -9'sd128;
    else                          s_sat = shifted[8:0];
  end

  // Noise comparison and clamp override applied at the moment stage 2 loads.
  always_comb begin
    sum     = {s_q[8], s_q} + {{2{r_q[7]}}, r_q};
    p_next  = ~sum[9];
    if (pb.clamp_en) p_next = pb.clamp_val;
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  end

  // Next-state logic for both pipeline stages and the LFSR.
  always_comb begin
    lfsr_d      = lfsr_q;
    s_d         = s_q;
    r_d         = r_q;
    s1_valid_d  = s1_valid_q;
    p_out_d     = p_out_q;
    out_valid_d = out_valid_q & ~pb.out_ready;
    if (accept) begin
      // r is sampled from the pre-advance LFSR value.
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
      s_d    = s_sat;
      r_d    = $signed(lfsr_q[7:0]);
    end
    if (accept)           s1_valid_d = 1'b1;
    else if (stage2_load) s1_valid_d = 1'b0;
    if (stage2_load) begin
      p_out_d     = p_next;
      out_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= SEED_EFF;
      s_q         <= '0;
      r_q         <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      p_out_q     <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      s_q         <= s_d;
      r_q         <= r_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      p_out_q     <= p_out_d;
    end
  end

`ifdef PBIT_FLIP_CNT_EN
  logic [15:0] flip_q, flip_d;

  // Saturating count of loads that change the visible p-bit.
  always_comb begin
    flip_d = flip_q;
    if (stage2_load && (p_next != p_out_q) && (flip_q != 16'hFFFF))
      flip_d = flip_q + 16'd1;
  end

  // Flip counter register.
  always_ff @(posedge clk) begin
    if (rst) flip_q <= '0;
    else     flip_q <= flip_d;
  end

  assign flip_count_o = flip_q;
`endif

  assign pb.in_ready  = in_ready;
  assign pb.out_valid = out_valid_q;
  assign pb.p_out     = p_out_q;

endmodule

// File: tb/tb_pbit_update.sv
// Scoreboard bench for pbit_update: the driver predicts each update from a
// behavioural model at accept time; a monitor pops and compares on every update.
module tb_pbit_update;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pbit_update_if bus ();
`ifdef PBIT_FLIP_CNT_EN
  logic [15:0] flip_count;
`endif

  pbit_update #(.GAIN_SHIFT(4), .SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .pb  (bus.slave)
`ifdef PBIT_FLIP_CNT_EN
    ,
    .flip_count_o (flip_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          exp_q[$];
  logic [15:0] m_lfsr;
  int          ones = 0;
  int          upd  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: current times 16, clamped to +-128, plus signed low LFSR byte, sign test.
  function automatic bit model_p(input int i_cur, input logic [15:0] lf,
                                 input bit cen, input bit cval);
    int s;
    int r;
    logic [7:0] lo;
    if (cen) return cval;
    s = i_cur * 16;
    if (s > 128)  s = 128;
    if (s < -128) s = -128;
    lo = lf[7:0];
    r  = int'($signed(lo));
    return (s + r) >= 0;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] lf);
    logic fb;
    fb = ^(lf & 16'hB400);
    return {lf[14:0], fb};
  endfunction

  // One cycle of stimulus; records the expected update if the DUT accepts.
  task automatic step(input bit v, input logic signed [5:0] I, input bit ordy,
                      output bit acc);
    @(negedge clk);
    bus.in_valid  = v;
    bus.I_in      = I;
    bus.out_ready = ordy;
    #1;
    acc = v && bus.in_ready && !rst;
    if (acc) begin
      exp_q.push_back(model_p(int'(I), m_lfsr, bus.clamp_en, bus.clamp_val));
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  task automatic drain(input string nm);
    int  n;
    bit  acc;
    n = 0;
    do begin
      step(1'b0, 6'sd0, 1'b1, acc);
      n++;
    end while ((exp_q.size() != 0 || bus.out_valid) && n < 20);
    chk({nm, "_drained"}, int'(exp_q.size() == 0 && !bus.out_valid), 1);
  endtask

  // Monitor: an update happens at the coming edge when out_valid & out_ready.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_update: got p_out=%0d expected no update", bus.p_out);
        end else begin
          e = exp_q.pop_front();
          chk("p_out", int'(bus.p_out), int'(e));
          if (bus.p_out) ones++;
          upd++;
        end
      end
    end
  end

  initial begin
    bit acc;
    int nacc;
    int stalls;
    bit held;
    bus.in_valid  = 1'b0;
    bus.I_in      = '0;
    bus.clamp_en  = 1'b0;
    bus.clamp_val = 1'b0;
    bus.out_ready = 1'b0;
    m_lfsr = SEED;

    // Reset held two cycles.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_p_out", int'(bus.p_out), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);

    // Alternating saturated inputs from reset: every load flips the bit.
    for (int k = 0; k < 10; k++) step(1'b1, (k % 2 == 0) ? 6'sb011111 : 6'sb100000, 1'b1, acc);
    drain("alt");
`ifdef PBIT_FLIP_CNT_EN
    chk("flip_count", int'(flip_count), 10);
`endif

    // Saturation: positive then negative full-scale.
    ones = 0; upd = 0;
    for (int k = 0; k < 64; k++) step(1'b1, 6'sb011111, 1'b1, acc);
    drain("sat_pos");
    chk("sat_pos_ones", ones, 64);
    ones = 0; upd = 0;
    for (int k = 0; k < 64; k++) step(1'b1, 6'sb100000, 1'b1, acc);
    drain("sat_neg");
    chk("sat_neg_ones", ones, 0);

    // Randomness with I=0, back-to-back, no stalls expected.
    ones = 0; upd = 0; stalls = 0;
    for (int k = 0; k < 1024; k++) begin
      step(1'b1, 6'sd0, 1'b1, acc);
      if (!acc) stalls++;
    end
    drain("rand0");
    chk("rand0_updates", upd, 1024);
    chk("rand0_stalls", stalls, 0);
    chk("rand0_ones_in_range", int'(ones >= 462 && ones <= 562), 1);

    // Backpressure: 5 cycles of out_ready=0 with input valid.
    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 6'($urandom_range(0, 63)), 1'b0, acc);
      if (acc) nacc++;
      if (k == 2) held = bus.p_out;
    end
    chk("bp_accepts", nacc, 2);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    chk("bp_out_valid", int'(bus.out_valid), 1);
    chk("bp_p_out_stable", int'(bus.p_out), int'(held));
    drain("bp");

    // Clamp to -1 against a full positive current.
    bus.clamp_en = 1'b1; bus.clamp_val = 1'b0;
    ones = 0; upd = 0;
    for (int k = 0; k < 16; k++) step(1'b1, 6'sb011111, 1'b1, acc);
    drain("clamp");
    chk("clamp_ones", ones, 0);
    chk("clamp_updates", upd, 16);
    // Clamp with nothing pending leaves the bit alone.
    bus.clamp_val = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 6'sd0, 1'b1, acc);
    chk("clamp_idle_p_out", int'(bus.p_out), 0);
    bus.clamp_en = 1'b0;
    step(1'b1, 6'sb011111, 1'b1, acc);
    drain("unclamp");
    chk("unclamp_p_out", int'(bus.p_out), 1);

    // Randomised chunks; clamp settings change only between drained chunks.
    for (int c = 0; c < 6; c++) begin
      bus.clamp_en  = ($urandom_range(0, 3) == 0);
      bus.clamp_val = $urandom_range(0, 1);
      for (int k = 0; k < 150; k++)
        step($urandom_range(0, 3) != 0, 6'($urandom_range(0, 63)),
             $urandom_range(0, 2) != 0, acc);
      drain("rand_chunk");
    end
    bus.clamp_en = 1'b0;

    // Reset mid-operation discards in-flight work and restarts the LFSR.
    step(1'b1, 6'sb011111, 1'b0, acc);
    step(1'b1, 6'sb011111, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_p_out", int'(bus.p_out), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
`ifdef PBIT_FLIP_CNT_EN
    chk("midrst_flip_count", int'(flip_count), 0);
`endif
    exp_q.delete();
    m_lfsr = SEED;
    rst = 1'b0;
    ones = 0; upd = 0;
    for (int k = 0; k < 40; k++) step(1'b1, 6'sd0, 1'b1, acc);
    drain("post_rst");
    chk("post_rst_updates", upd, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule
